// File: rtl/timer_int_ctrl_pkg.sv
// Shared constants and types for the timer interrupt initiator.
// Holds the FSM encodings, the entry-strobe status value and the default
// handler vector so the register file and fetch logic agree on them.
package timer_int_ctrl_pkg;

  localparam int COUNT_W = 32;

  typedef enum logic [1:0] {
    TI_IDLE    = 2'd0,
    TI_TAKE    = 2'd1,
    TI_HANDLER = 2'd2,
    TI_RETURN  = 2'd3
  } ti_state_e;

  // Value seen by the register file on epce_o when r26 must capture the PC.
  localparam logic TIMER_INT_STATUS = 1'b1;

  localparam logic [31:0] DEFAULT_HANDLER_ADDR = 32'h0000_0040;

  // Counter reload value for a given expiry interval.
  function automatic logic [COUNT_W-1:0] reload_value(input logic [COUNT_W-1:0] period);
    return period - {{(COUNT_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/timer_int_ctrl_counter.sv
// Reloadable free-running down-counter. expire is high during the cycle the
// count sits at zero while enabled; the same edge reloads PERIOD-1.
module timer_counter
  import timer_int_ctrl_pkg::*;
#(
  parameter logic [COUNT_W-1:0] PERIOD = 32'd1000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  output logic [COUNT_W-1:0] count,
  output logic               expire
);

  localparam logic [COUNT_W-1:0] RELOAD = reload_value(PERIOD);

  assign expire = en && (count == '0);

  // Count down while enabled, wrapping to the reload value after zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= RELOAD;
    end else if (en) begin
      if (expire) begin
        count <= RELOAD;
      end else begin
        count <= count - {{(COUNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: rtl/timer_int_ctrl.sv
// Timer interrupt initiator for the five-stage pipeline. Latches a single
// timer expiry, waits for a non-stalled cycle, then flushes and redirects
// fetch to the handler; on eret it redirects back to the r26 address.
module timer_int_ctrl
  import timer_int_ctrl_pkg::*;
#(
  parameter logic [COUNT_W-1:0] PERIOD       = 32'd1000,
  parameter int                 ADDR_W       = 32,
  parameter logic [ADDR_W-1:0]  HANDLER_ADDR = ADDR_W'(DEFAULT_HANDLER_ADDR)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               timer_en_i,
  input  logic               stall_i,
  input  logic               eret_i,
  input  logic [ADDR_W-1:0]  epc_i,
  output logic               epce_o,
  output logic               flush_o,
  output logic               redirect_o,
  output logic [ADDR_W-1:0]  redirect_pc_o,
  output logic               in_handler_o,
  output logic               pending_o,
  output logic [COUNT_W-1:0] count_o
);

  ti_state_e state;
  ti_state_e next_state;
  logic      pending;
  logic      next_pending;
  logic      expire;

  // The top address bit of r26 is forced low on return, so it is never read.
  logic unused_epc_msb;
  assign unused_epc_msb = epc_i[ADDR_W-1];

  timer_counter #(
    .PERIOD (PERIOD)
  ) u_counter (
    .clk    (clk),
    .rst    (rst),
    .en     (timer_en_i),
    .count  (count_o),
    .expire (expire)
  );

  // State and pending-flag registers; reset abandons any pending expiry.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= TI_IDLE;
      pending <= 1'b0;
    end else begin
      state   <= next_state;
      pending <= next_pending;
    end
  end

  // Next-state logic; a new expiry beats the clear issued by TAKE.
  always_comb begin
    next_state   = state;
    next_pending = pending;
    if (expire) begin
      next_pending = 1'b1;
    end else if (state == TI_TAKE) begin
      next_pending = 1'b0;
    end
    case (state)
      TI_IDLE: begin
        if (pending && !stall_i) begin
          next_state = TI_TAKE;
        end
      end
      TI_TAKE: begin
        next_state = TI_HANDLER;
      end
      TI_HANDLER: begin
        if (eret_i) begin
          next_state = TI_RETURN;
        end
      end
      TI_RETURN: begin
        next_state = TI_IDLE;
      end
      default: begin
        next_state = TI_IDLE;
      end
    endcase
  end

  assign epce_o       = (state == TI_TAKE) ? TIMER_INT_STATUS : ~TIMER_INT_STATUS;
  assign flush_o      = (state == TI_TAKE) || (state == TI_RETURN);
  assign redirect_o   = (state == TI_TAKE) || (state == TI_RETURN);
  assign in_handler_o = (state == TI_HANDLER);
  assign pending_o    = pending;

  // PC override: handler vector on entry, r26 with the top bit cleared on return.
  always_comb begin
    redirect_pc_o = '0;
    if (state == TI_TAKE) begin
      redirect_pc_o = HANDLER_ADDR;
    end else if (state == TI_RETURN) begin
      redirect_pc_o = {1'b0, epc_i[ADDR_W-2:0]};
    end
  end

endmodule

// File: tb/tb_timer_int_ctrl.sv
// Scoreboard bench for timer_int_ctrl with PERIOD=4 and HANDLER_ADDR=32'h40.
// The stimulus process queues the expected outputs from a cycle-level
// reference model; a monitor process pops and compares them every cycle.
module tb_timer_int_ctrl;

  localparam logic [31:0] P     = 32'd4;
  localparam logic [31:0] HADDR = 32'h0000_0040;

  logic        clk = 1'b0;
  logic        rst;
  logic        timer_en_i;
  logic        stall_i;
  logic        eret_i;
  logic [31:0] epc_i;
  logic        epce_o;
  logic        flush_o;
  logic        redirect_o;
  logic [31:0] redirect_pc_o;
  logic        in_handler_o;
  logic        pending_o;
  logic [31:0] count_o;

  typedef struct packed {
    logic        epce;
    logic        flush;
    logic        redirect;
    logic [31:0] pc;
    logic        inh;
    logic        pend;
    logic [31:0] cnt;
  } exp_t;

  exp_t        expQ[$];
  logic [31:0] redirQ[$];
  int          checks = 0;
  int          errors = 0;

  int unsigned mCnt   = 0;
  bit          mPend  = 1'b0;
  bit          mTake  = 1'b0;
  bit          mRet   = 1'b0;
  bit          mIsr   = 1'b0;
  bit          mValid = 1'b0;

  // Free-running clock.
  always #5 clk = ~clk;

  timer_int_ctrl #(
    .PERIOD       (P),
    .ADDR_W       (32),
    .HANDLER_ADDR (HADDR)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .timer_en_i    (timer_en_i),
    .stall_i       (stall_i),
    .eret_i        (eret_i),
    .epc_i         (epc_i),
    .epce_o        (epce_o),
    .flush_o       (flush_o),
    .redirect_o    (redirect_o),
    .redirect_pc_o (redirect_pc_o),
    .in_handler_o  (in_handler_o),
    .pending_o     (pending_o),
    .count_o       (count_o)
  );

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    cmp("epce_o", {31'd0, epce_o}, {31'd0, e.epce});
    cmp("flush_o", {31'd0, flush_o}, {31'd0, e.flush});
    cmp("redirect_o", {31'd0, redirect_o}, {31'd0, e.redirect});
    cmp("redirect_pc_o", redirect_pc_o, e.pc);
    cmp("in_handler_o", {31'd0, in_handler_o}, {31'd0, e.inh});
    cmp("pending_o", {31'd0, pending_o}, {31'd0, e.pend});
    cmp("count_o", count_o, e.cnt);
  endtask

  // Advance the reference model across one clock edge.
  task automatic modelStep(input bit r, input bit en, input bit st, input bit er);
    bit          expired;
    int unsigned nCnt;
    bit          nPend, nTake, nRet, nIsr;
    if (r) begin
      mCnt   = P - 1;
      mPend  = 1'b0;
      mTake  = 1'b0;
      mRet   = 1'b0;
      mIsr   = 1'b0;
      mValid = 1'b1;
    end else begin
      expired = en && (mCnt == 0);
      nCnt    = !en ? mCnt : (mCnt == 0 ? P - 1 : mCnt - 1);
      nPend   = expired || (mPend && !mTake);
      nTake   = mPend && !st && !mIsr && !mTake && !mRet;
      nIsr    = mTake || (mIsr && !er);
      nRet    = mIsr && er;
      mCnt    = nCnt;
      mPend   = nPend;
      mTake   = nTake;
      mIsr    = nIsr;
      mRet    = nRet;
    end
  endtask

  task automatic applyStimulus(input bit r, input bit en, input bit st, input bit er,
                               input logic [31:0] epc);
    exp_t        e;
    logic [31:0] pcExp;
    @(negedge clk);
    rst        = r;
    timer_en_i = en;
    stall_i    = st;
    eret_i     = er;
    epc_i      = epc;
    if (mValid) begin
      pcExp      = mTake ? HADDR : (mRet ? {1'b0, epc[30:0]} : 32'h0);
      e.epce     = mTake;
      e.flush    = mTake || mRet;
      e.redirect = mTake || mRet;
      e.pc       = pcExp;
      e.inh      = mIsr;
      e.pend     = mPend;
      e.cnt      = mCnt;
      expQ.push_back(e);
      if (mTake || mRet) redirQ.push_back(pcExp);
    end
    modelStep(r, en, st, er);
  endtask

  // Monitor: compare every cycle's outputs and every redirect event.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput(e);
      end
      if (redirect_o === 1'b1) begin
        if (redirQ.size() == 0) cmp("redirect_unexpected", {31'd0, redirect_o}, 32'd0);
        else cmp("redirect_event_pc", redirect_pc_o, redirQ.pop_front());
      end
    end
  end

  // Directed scenarios followed by randomized traffic.
  initial begin
    rst        = 1'b1;
    timer_en_i = 1'b0;
    stall_i    = 1'b0;
    eret_i     = 1'b0;
    epc_i      = 32'h0;

    // Reset, free run to the first TAKE, stay in handler past an expiry.
    applyStimulus(1, 0, 0, 0, 32'h0);
    applyStimulus(1, 0, 0, 0, 32'h0);
    repeat (13) applyStimulus(0, 1, 0, 0, 32'h0);
    // eret with r26 = 8000_1234, held valid into RETURN, then back-to-back TAKE.
    applyStimulus(0, 1, 0, 1, 32'h8000_1234);
    applyStimulus(0, 1, 0, 0, 32'h8000_1234);
    repeat (4) applyStimulus(0, 1, 0, 0, 32'h0);

    // eret in IDLE with nothing pending is ignored.
    applyStimulus(1, 0, 0, 0, 32'h0);
    applyStimulus(0, 0, 0, 1, 32'hDEAD_BEEF);
    repeat (3) applyStimulus(0, 0, 0, 0, 32'hDEAD_BEEF);

    // Stall holds off the take while pending.
    repeat (10) applyStimulus(0, 1, 1, 0, 32'h0);
    repeat (3) applyStimulus(0, 1, 0, 0, 32'h0);

    // Run in handler until another expiry is pending, then reset.
    repeat (5) applyStimulus(0, 1, 0, 0, 32'h0);
    applyStimulus(1, 1, 0, 0, 32'h0);
    repeat (3) applyStimulus(0, 0, 0, 0, 32'h0);

    // Randomized traffic.
    repeat (600) begin
      applyStimulus($urandom_range(0, 63) == 0, $urandom_range(0, 9) < 8,
                    $urandom_range(0, 9) < 3, $urandom_range(0, 4) == 0, $urandom);
    end

    @(negedge clk);
    #3;
    cmp("scoreboard_drained", expQ.size(), 32'd0);
    cmp("redirect_queue_drained", redirQ.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
